// File: rtl/sel_pipe_mux.sv
// Registered N-channel select mux with a one-entry skid buffer behind the output register.
// Out-of-range selects route zero and set a sticky error; flush drops everything buffered.
//
// state | meaning
// EMPTY | no word held; out_valid=0
// ONE   | main register holds a word; skid empty
// FULL  | main and skid both hold words; in_ready=0
module sel_pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err
);

  // Encoding chosen so bit0 is main_valid and bit1 is skid_valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data, skid_data;
  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             acc, snd;
  logic             load_main, load_skid, main_from_skid;

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign out_data  = main_data;
  assign acc       = in_valid & in_ready;
  assign snd       = out_valid & out_ready;

  always_comb begin
    sel_word = '0;
    sel_bad  = (int'(in_sel) >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(in_sel) == k) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (acc && snd) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (snd) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (snd) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush empties both entries and leaves out_data holding its last value.
    if (flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      sel_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main)           main_data <= sel_word;
      else if (main_from_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= sel_word;
      if (acc && sel_bad)      sel_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Directed bench for sel_pipe_mux: a 4-channel 32-bit instance for streaming, stall,
// flush and reset cases, and a 3-channel 8-bit instance for out-of-range selects.
module tb_sel_pipe_mux;

  logic         clk = 1'b0;
  logic         rst;

  logic [127:0] a_in_data;
  logic [1:0]   a_in_sel;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_sel_err;
  logic [31:0]  a_out_data;

  logic [23:0]  b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_sel_err;
  logic [7:0]   b_out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sel_pipe_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .flush(a_flush), .sel_err(a_sel_err)
  );

  sel_pipe_mux #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .flush(b_flush), .sel_err(b_sel_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer_a(input logic [31:0] w);
    a_in_data  = {96'h0, w};
    a_in_sel   = 2'd0;
    a_in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    a_in_sel = 2'd1; a_in_valid = 1'b1; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_data = {8'hB2, 8'hB1, 8'hB0};
    b_in_sel = 2'd0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0;

    // Reset held two cycles with a word offered
    step(); step();
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("rst_sel_err", {31'b0, a_sel_err}, 32'd0);
    rst = 1'b0; a_in_valid = 1'b0;
    step();
    chk("post_rst_out_valid", {31'b0, a_out_valid}, 32'd0);

    // Back-to-back stream, one word per cycle
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    a_in_sel = 2'd0; step();
    chk("stream0", a_out_data, 32'hA0);
    chk("stream0_valid", {31'b0, a_out_valid}, 32'd1);
    a_in_sel = 2'd1; step();
    chk("stream1", a_out_data, 32'hA1);
    chk("stream1_valid", {31'b0, a_out_valid}, 32'd1);
    a_in_sel = 2'd2; step();
    chk("stream2", a_out_data, 32'hA2);
    chk("stream2_ready", {31'b0, a_in_ready}, 32'd1);
    a_in_sel = 2'd3; step();
    chk("stream3", a_out_data, 32'hA3);
    chk("stream3_valid", {31'b0, a_out_valid}, 32'd1);
    a_in_valid = 1'b0; step();
    chk("stream_drain_valid", {31'b0, a_out_valid}, 32'd0);

    // Backpressure: 0x11 in main, 0x22 in skid, 0x33 held upstream
    a_out_ready = 1'b0;
    offer_a(32'h11); step();
    chk("bp_main", a_out_data, 32'h11);
    chk("bp_ready_one", {31'b0, a_in_ready}, 32'd1);
    offer_a(32'h22); step();
    chk("bp_hold_full", a_out_data, 32'h11);
    chk("bp_ready_full", {31'b0, a_in_ready}, 32'd0);
    offer_a(32'h33); step();
    chk("bp_stall_data", a_out_data, 32'h11);
    chk("bp_stall_valid", {31'b0, a_out_valid}, 32'd1);
    chk("bp_stall_ready", {31'b0, a_in_ready}, 32'd0);
    a_out_ready = 1'b1; step();
    chk("bp_out22", a_out_data, 32'h22);
    chk("bp_ready_again", {31'b0, a_in_ready}, 32'd1);
    step();
    chk("bp_out33", a_out_data, 32'h33);
    chk("bp_out33_valid", {31'b0, a_out_valid}, 32'd1);
    a_in_valid = 1'b0; step();
    chk("bp_drain_valid", {31'b0, a_out_valid}, 32'd0);

    // Flush in FULL with a word offered
    a_out_ready = 1'b0;
    offer_a(32'h44); step();
    offer_a(32'h55); step();
    chk("fl_full_ready", {31'b0, a_in_ready}, 32'd0);
    offer_a(32'h66); a_flush = 1'b1; step();
    chk("fl_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("fl_data_kept", a_out_data, 32'h44);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; step();
    chk("fl_no_ghost", {31'b0, a_out_valid}, 32'd0);

    // Flush in ONE while a word is accepted: that word is dropped
    a_out_ready = 1'b0;
    offer_a(32'h77); step();
    offer_a(32'h88); a_flush = 1'b1; step();
    chk("fl1_out_valid", {31'b0, a_out_valid}, 32'd0);
    a_flush = 1'b0; a_in_valid = 1'b0; step();
    chk("fl1_no_ghost", {31'b0, a_out_valid}, 32'd0);

    // Reset while FULL and stalled
    offer_a(32'h91); step();
    offer_a(32'h92); step();
    chk("mr_full", {31'b0, a_in_ready}, 32'd0);
    rst = 1'b1; step();
    chk("mr_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("mr_out_data", a_out_data, 32'h0);
    chk("mr_in_ready", {31'b0, a_in_ready}, 32'd1);
    rst = 1'b0; offer_a(32'h93); a_out_ready = 1'b1; step();
    chk("mr_first_word", a_out_data, 32'h93);
    chk("mr_first_valid", {31'b0, a_out_valid}, 32'd1);
    a_in_valid = 1'b0; step();
    chk("mr_sel_err_a", {31'b0, a_sel_err}, 32'd0);

    // Out-of-range select on the 3-channel instance
    b_in_valid = 1'b1; b_in_sel = 2'd3; step();
    chk("bad_sel_data", {24'h0, b_out_data}, 32'h0);
    chk("bad_sel_valid", {31'b0, b_out_valid}, 32'd1);
    chk("bad_sel_err", {31'b0, b_sel_err}, 32'd1);
    b_in_sel = 2'd1; step();
    chk("good_sel_data", {24'h0, b_out_data}, 32'hB1);
    chk("good_sel_err_sticky", {31'b0, b_sel_err}, 32'd1);
    b_in_valid = 1'b0; b_in_sel = 2'd3; step();
    chk("idle_bad_sel_sticky", {31'b0, b_sel_err}, 32'd1);
    chk("idle_valid", {31'b0, b_out_valid}, 32'd0);
    rst = 1'b1; step();
    chk("rst_clears_sel_err", {31'b0, b_sel_err}, 32'd0);
    rst = 1'b0; b_in_valid = 1'b1; b_in_sel = 2'd2; step();
    chk("post_rst_ch2", {24'h0, b_out_data}, 32'hB2);
    chk("post_rst_no_err", {31'b0, b_sel_err}, 32'd0);
    b_in_valid = 1'b0; step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
